// File: rtl/tick_scheduler.sv
// tick_scheduler: free-running pixel / scan enables plus a start/pause/stop
// game-step scheduler with a step request handshake and overrun detection.
// Optional feature: define TICK_OVERRUN_CNT_EN to build the saturating
// 8-bit overrun event counter; otherwise overrun_cnt is tied to zero.
module tick_scheduler #(
    parameter int SCAN_DIV  = 262144,
    parameter int STEP_BASE = 16777216
) (
    input  logic       clk_100M,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    input  logic [1:0] speed,
    input  logic       step_ack,
    output logic       pix_en,
    output logic       scan_en,
    output logic       step_req,
    output logic [1:0] state,
    output logic       overrun,
    output logic [7:0] overrun_cnt
);

    // Scan counter only needs to reach SCAN_DIV-1; the step counter width also
    // holds the full period value STEP_BASE so the shifted period fits.
    localparam int SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = $clog2(STEP_BASE) + 1;

    localparam logic [SW-1:0] SCAN_LAST   = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] STEP_BASE_W = CW'(STEP_BASE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    pix_cnt_q;
    logic          pix_en_q;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic          scan_en_q;
    logic [CW-1:0] step_cnt_q, step_cnt_d;
    logic          step_req_q, step_req_d;
    logic          overrun_q, overrun_d;

    logic [CW-1:0] step_period;
    logic          step_term;
    logic          run_entry;
    logic          ovr_evt;

    // FSM next state: stop beats pause, pause beats start.
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (start)  state_d = ST_RUN;
                ST_RUN:    if (pause)  state_d = ST_PAUSED;
                ST_PAUSED: if (!pause) state_d = ST_RUN;
                default:               state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Step terminal uses >= so a speed change that shortens the period
    // mid-count fires on the very next RUN cycle instead of wrapping.
    assign step_period = STEP_BASE_W >> speed;
    assign step_term   = (state_q == ST_RUN) && (step_cnt_q >= step_period - CW'(1));
    assign run_entry   = (state_q == ST_IDLE) && (state_d == ST_RUN);
    assign ovr_evt     = step_term && step_req_q && !step_ack;

    // Datapath next values: scan wrap, step count, request and overrun flags.
    always_comb begin
        scan_cnt_d = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + SW'(1);

        step_cnt_d = step_cnt_q;
        if ((state_d == ST_IDLE) || run_entry) begin
            step_cnt_d = '0;
        end else if (state_q == ST_RUN) begin
            step_cnt_d = step_term ? '0 : step_cnt_q + CW'(1);
        end

        // A new terminal outranks an acknowledge in the same cycle.
        step_req_d = step_req_q;
        if (state_d == ST_IDLE) begin
            step_req_d = 1'b0;
        end else if (step_term) begin
            step_req_d = 1'b1;
        end else if (step_ack) begin
            step_req_d = 1'b0;
        end

        overrun_d = overrun_q;
        if (run_entry) begin
            overrun_d = 1'b0;
        end else if (ovr_evt) begin
            overrun_d = 1'b1;
        end
    end

    // Timing counters, registered enables and scheduler flags.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt_q  <= '0;
            pix_en_q   <= 1'b0;
            scan_cnt_q <= '0;
            scan_en_q  <= 1'b0;
            step_cnt_q <= '0;
            step_req_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            pix_cnt_q  <= pix_cnt_q + 2'd1;
            pix_en_q   <= (pix_cnt_q == 2'd3);
            scan_cnt_q <= scan_cnt_d;
            scan_en_q  <= (scan_cnt_q == SCAN_LAST);
            step_cnt_q <= step_cnt_d;
            step_req_q <= step_req_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef TICK_OVERRUN_CNT_EN
    logic [7:0] ovr_cnt_q, ovr_cnt_d;

    // Overrun event counter: saturates at 255, clears together with overrun.
    always_comb begin
        ovr_cnt_d = ovr_cnt_q;
        if (run_entry) begin
            ovr_cnt_d = 8'd0;
        end else if (ovr_evt && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    // Overrun counter register.
    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            ovr_cnt_q <= 8'd0;
        end else begin
            ovr_cnt_q <= ovr_cnt_d;
        end
    end

    assign overrun_cnt = ovr_cnt_q;
`else
    assign overrun_cnt = 8'd0;
`endif

    assign pix_en   = pix_en_q;
    assign scan_en  = scan_en_q;
    assign step_req = step_req_q;
    assign state    = state_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler: directed scenarios with literal expectations
// plus randomized stimulus checked every cycle against a behavioural model.
module tb_tick_scheduler;

    localparam int SCAN_DIV  = 8;
    localparam int STEP_BASE = 32;

    logic       clk_100M = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       pause    = 1'b0;
    logic       stop     = 1'b0;
    logic [1:0] speed    = 2'd0;
    logic       step_ack = 1'b0;
    logic       pix_en, scan_en, step_req, overrun;
    logic [1:0] state;
    logic [7:0] overrun_cnt;

    int  errors = 0;
    int  checks = 0;
    bit  chk_en = 1'b0;

    always #5 clk_100M = ~clk_100M;

    tick_scheduler #(
        .SCAN_DIV  (SCAN_DIV),
        .STEP_BASE (STEP_BASE)
    ) dut (
        .clk_100M    (clk_100M),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .stop        (stop),
        .speed       (speed),
        .step_ack    (step_ack),
        .pix_en      (pix_en),
        .scan_en     (scan_en),
        .step_req    (step_req),
        .state       (state),
        .overrun     (overrun),
        .overrun_cnt (overrun_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // cyc counts rising edges since reset release; enables follow from it.
    int cyc;
    int m_state;    // 0 idle, 1 run, 2 paused
    int m_cnt;      // RUN cycles elapsed in the current step period
    bit m_req;
    bit m_ovr;
    int m_ocnt;
    int t_per, t_ns;
    bit t_term, t_evt;

    always @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; m_state = 0; m_cnt = 0; m_req = 0; m_ovr = 0; m_ocnt = 0;
        end else begin
            cyc    = cyc + 1;
            t_per  = STEP_BASE >> speed;
            t_term = (m_state == 1) && (m_cnt >= t_per - 1);
            t_evt  = t_term && m_req && !step_ack;
            if (stop)                          t_ns = 0;
            else if (m_state == 0 && start)    t_ns = 1;
            else if (m_state == 1 && pause)    t_ns = 2;
            else if (m_state == 2 && !pause)   t_ns = 1;
            else                               t_ns = m_state;

            if (m_state == 0 && t_ns == 1) begin
                m_cnt = 0; m_ovr = 0; m_ocnt = 0;
            end else begin
                if (t_evt) begin
                    m_ovr = 1;
                    if (m_ocnt < 255) m_ocnt = m_ocnt + 1;
                end
                if (m_state == 1) m_cnt = t_term ? 0 : m_cnt + 1;
            end
            if (t_ns == 0) begin
                m_cnt = 0; m_req = 0;
            end else if (t_term) m_req = 1;
            else if (step_ack)   m_req = 0;
            m_state = t_ns;
        end
    end

    function automatic int exp_ocnt(input int v);
`ifdef TICK_OVERRUN_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Single compare process against the model, away from the active edge.
    always @(negedge clk_100M) begin
        if (rst_n && chk_en) begin
            chk("pix_en",      pix_en,      (cyc > 0 && cyc % 4 == 0) ? 1 : 0);
            chk("scan_en",     scan_en,     (cyc > 0 && cyc % SCAN_DIV == 0) ? 1 : 0);
            chk("state",       state,       m_state);
            chk("step_req",    step_req,    m_req);
            chk("overrun",     overrun,     m_ovr);
            chk("overrun_cnt", overrun_cnt, exp_ocnt(m_ocnt));
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk_100M);
        #1;
    endtask

    task automatic wait_req(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            tick();
            if (step_req) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_pix"},   pix_en,      0);
        chk({tag, "_scan"},  scan_en,     0);
        chk({tag, "_state"}, state,       0);
        chk({tag, "_req"},   step_req,    0);
        chk({tag, "_ovr"},   overrun,     0);
        chk({tag, "_ocnt"},  overrun_cnt, 0);
    endtask

    task automatic go_run(input logic [1:0] spd);
        stop = 1'b1; tick(); stop = 1'b0;
        speed = spd; start = 1'b1; tick(); start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] pix_pat;
    logic [15:0] scan_pat;
    int n;

    initial begin
        pix_pat  = 16'b1000_1000_1000_1000;
        scan_pat = 16'b1000_0000_1000_0000;

        // Reset state
        tick(); tick();
        chk_all_zero("reset");
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Idle enables over 16 cycles
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk($sformatf("idle_pix_c%0d", k),  pix_en,  int'(pix_pat[k-1]));
            chk($sformatf("idle_scan_c%0d", k), scan_en, int'(scan_pat[k-1]));
            chk("idle_state", state, 0);
            chk("idle_req", step_req, 0);
        end
        $display("idle enables: 16 cycles done");

        // Handshake at speed 0: one request per 32 cycles, never overrun
        go_run(2'd0);
        chk("run_state", state, 1);
        wait_req(40, n);
        chk("first_req_latency", n, 32);
        for (int r = 0; r < 3; r++) begin
            tick(); tick();
            step_ack = 1'b1; tick(); step_ack = 1'b0;
            chk("req_cleared_by_ack", step_req, 0);
            wait_req(40, n);
            chk("req_period", (n < 0) ? n : n + 3, 32);
            chk("no_overrun", overrun, 0);
            $display("handshake step %0d: period %0d", r, n + 3);
        end

        // No acknowledge at speed 2: overrun at second terminal
        go_run(2'd2);
        wait_req(20, n);
        chk("spd2_first_req", n, 8);
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 7) chk("ovr_before_2nd_term", overrun, 0);
        end
        chk("ovr_at_2nd_term", overrun, 1);
        chk("ocnt_1", overrun_cnt, exp_ocnt(1));
        for (int i = 0; i < 8; i++) tick();
        chk("ocnt_2", overrun_cnt, exp_ocnt(2));
        for (int i = 0; i < 8; i++) tick();
        chk("ocnt_3", overrun_cnt, exp_ocnt(3));
        chk("single_req_queued", step_req, 1);
        $display("overrun sequence: cnt=%0d", overrun_cnt);

        // Saturation at 255 with a period of 4
        speed = 2'd3;
        for (int i = 0; i < 4 * 260; i++) tick();
        chk("ocnt_saturated", overrun_cnt, exp_ocnt(255));
        $display("saturation: cnt=%0d", overrun_cnt);

        // stop+start together while requesting; stop wins, then restart
        stop = 1'b1; start = 1'b1; tick();
        chk("stop_state", state, 0);
        chk("stop_req", step_req, 0);
        chk("stop_keeps_ovr", overrun, 1);
        stop = 1'b0; speed = 2'd2;
        wait_req(20, n);
        start = 1'b0;
        chk("restart_latency", n, 9);
        chk("restart_clears_ovr", overrun, 0);
        $display("stop/start restart: latency %0d", n);

        // Pause at step count 10 for 50 cycles, then resume
        go_run(2'd0);
        for (int i = 0; i < 10; i++) tick();
        pause = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("paused_state", state, 2);
            chk("paused_no_req", step_req, 0);
        end
        pause = 1'b0;
        wait_req(40, n);
        chk("resume_latency", n, 22);
        $display("pause/resume: latency %0d", n);

        // Asynchronous reset mid-count with a pending request
        for (int i = 0; i < 5; i++) tick();
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        tick();
        chk_all_zero("held_rst");
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("post_rst_pix_c%0d", k), pix_en, (k == 4) ? 1 : 0);
        end
        $display("async reset: outputs cleared without an edge");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            start    = ($urandom % 8) == 0;
            stop     = ($urandom % 64) == 0;
            if (($urandom % 20) == 0) pause = ~pause;
            if (($urandom % 50) == 0) speed = 2'($urandom % 4);
            step_ack = ($urandom % 3) == 0;
            tick();
        end
        $display("random phase: 3000 cycles done");

        @(negedge clk_100M);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
